// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the UART word transmitter.
//   state_t             : frame sequencer states
//   HEADER_BYTE_DEFAULT : default first character of every frame
package uart_word_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_word_tx.sv
// uart_word_tx: client-side driver for a UART TX core. Accepts one wide word
// and sends it as a frame: HEADER_BYTE, WORD_BYTES payload characters and,
// when UART_WORD_TX_CHECKSUM_EN is defined, an XOR checksum of the payload.
//
// Ports
//   clk            : system clock
//   resetn         : asynchronous reset, active low
//   word_in        : word to send, sampled on accept (word_valid & word_ready)
//   word_valid     : send request
//   word_ready     : high only while idle
//   done           : one-cycle pulse after the last character has finished
//   uart_data      : character for the UART, held from ISSUE through WAIT_DONE
//   uart_tx_enable : one-cycle start pulse per character
//   uart_tx_busy   : UART busy flag
//
// Configuration macro: UART_WORD_TX_CHECKSUM_EN (appends XOR checksum char).
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int unsigned           DATA_BITS   = 8,
  parameter int unsigned           WORD_BYTES  = 8,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter logic [DATA_BITS-1:0]  HEADER_BYTE = DATA_BITS'(HEADER_BYTE_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_BITS*WORD_BYTES-1:0] word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic                          done,
  output logic [DATA_BITS-1:0]          uart_data,
  output logic                          uart_tx_enable,
  input  logic                          uart_tx_busy
);

  localparam int unsigned W     = DATA_BITS * WORD_BYTES;
  localparam int unsigned IDX_W = $clog2(WORD_BYTES + 2);
`ifdef UART_WORD_TX_CHECKSUM_EN
  localparam int unsigned LAST_CHAR = WORD_BYTES + 1;
`else
  localparam int unsigned LAST_CHAR = WORD_BYTES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(LAST_CHAR);
  localparam logic [IDX_W-1:0] PAYLOAD_END = IDX_W'(WORD_BYTES);

  state_t                 state;
  logic [IDX_W-1:0]       index;
  logic [W-1:0]           shift_q;
  logic [W-1:0]           shift_next;
  logic [DATA_BITS-1:0]   head_char;
`ifdef UART_WORD_TX_CHECKSUM_EN
  logic [DATA_BITS-1:0]   csum;
`endif

  // The next payload character always sits at the leading end of the shift
  // register; the register advances by one character each time one is loaded.
  always_comb begin
    head_char  = '0;
    shift_next = '0;
    if (MSB_FIRST) begin
      head_char  = shift_q[W-1 -: DATA_BITS];
      shift_next = shift_q << DATA_BITS;
    end else begin
      head_char  = shift_q[DATA_BITS-1:0];
      shift_next = shift_q >> DATA_BITS;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      word_ready     <= 1'b1;
      done           <= 1'b0;
      uart_tx_enable <= 1'b0;
      uart_data      <= '0;
      index          <= '0;
      shift_q        <= '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      uart_tx_enable <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid) begin
            state      <= ISSUE;
            word_ready <= 1'b0;
            shift_q    <= word_in;
            index      <= '0;
            uart_data  <= HEADER_BYTE;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        ISSUE: begin
          if (!uart_tx_busy) begin
            uart_tx_enable <= 1'b1;
            state          <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (index == LAST_IDX) begin
              state      <= IDLE;
              word_ready <= 1'b1;
              done       <= 1'b1;
            end else begin
              index <= index + 1'b1;
              state <= ISSUE;
`ifdef UART_WORD_TX_CHECKSUM_EN
              // Payload chars fold into the checksum as they are loaded, so it
              // is complete by the time the trailing checksum char is due.
              if (index < PAYLOAD_END) begin
                uart_data <= head_char;
                shift_q   <= shift_next;
                csum      <= csum ^ head_char;
              end else begin
                uart_data <= csum;
              end
`else
              uart_data <= head_char;
              shift_q   <= shift_next;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
